// File: rtl/washing_machine_ctrl_multi.sv
// washing_machine_ctrl_multi: washer sequencer with counter-timed phases, mode-selected rinse passes, pause and fill/drain watchdogs.
// Optional presoak stage for heavy mode is enabled by defining PRESOAK_EN.
module washing_machine_ctrl_multi #(
    parameter int TIMER_W       = 16,
    parameter int WASH_TICKS    = 1000,
    parameter int RINSE_TICKS   = 600,
    parameter int SPIN_TICKS    = 800,
    parameter int FILL_TIMEOUT  = 2000,
    parameter int DRAIN_TIMEOUT = 2000,
    parameter int MAX_RINSE     = 3
`ifdef PRESOAK_EN
    ,
    parameter int SOAK_TICKS    = 500
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       door_close,
    input  logic       filled,
    input  logic       detergent_added,
    input  logic       drained,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_valve_on,
    output logic       drain_valve_on,
    output logic       water_wash,
    output logic       done,
    output logic       fault,
    output logic [3:0] state_out
);
    localparam longint TMAX = longint'(1) << TIMER_W;
    localparam bit BAD_CFG = WASH_TICKS < 1 || RINSE_TICKS < 1 || SPIN_TICKS < 1 ||
        FILL_TIMEOUT < 1 || DRAIN_TIMEOUT < 1 || MAX_RINSE < 1 || MAX_RINSE > 7 ||
        longint'(WASH_TICKS) > TMAX || longint'(RINSE_TICKS) > TMAX || longint'(SPIN_TICKS) > TMAX ||
        longint'(FILL_TIMEOUT) > TMAX || longint'(DRAIN_TIMEOUT) > TMAX;
    if (BAD_CFG) begin : g_bad_cfg
        $error("washing_machine_ctrl_multi: phase lengths/timeouts must be >=1 and fit TIMER_W, MAX_RINSE in 1..7");
    end

    localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_TICKS - 1);
    localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_TICKS - 1);
    localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);
    localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FILL  = 4'd1,
        WASH  = 4'd2,
        DRAIN = 4'd3,
        RINSE = 4'd4,
        SPIN  = 4'd5,
        DONE  = 4'd6,
        FAULT = 4'd7
`ifdef PRESOAK_EN
        ,
        SOAK  = 4'd8
`endif
    } state_t;

    state_t state, state_nx, first_dest;
    logic [TIMER_W-1:0] timer;
    logic [2:0] rinse_cnt, rinse_target;
    logic timed, door_bad;

`ifdef PRESOAK_EN
    localparam logic [TIMER_W-1:0] SOAK_LAST = TIMER_W'(SOAK_TICKS - 1);
    logic heavy;
    always_ff @(posedge clk) begin
        if (reset) heavy <= 1'b0;
        else if (state == IDLE && state_nx == FILL) heavy <= mode == 2'd2;
    end
    assign first_dest = heavy ? SOAK : WASH;
    assign timed = state == WASH || state == RINSE || state == SPIN || state == SOAK;
`else
    assign first_dest = WASH;
    assign timed = state == WASH || state == RINSE || state == SPIN;
`endif

    assign door_bad = !door_close && state != IDLE && state != DONE && state != FAULT;

    always_comb begin
        state_nx = state;
        if (door_bad) state_nx = FAULT;
        else case (state)
            IDLE:  if (start && door_close) state_nx = FILL;
            FILL:  if (filled && (rinse_cnt != 3'd0 || detergent_added)) state_nx = rinse_cnt != 3'd0 ? RINSE : first_dest;
                   else if (timer == FILL_LAST) state_nx = FAULT;
            WASH:  if (!pause && timer == WASH_LAST) state_nx = DRAIN;
            DRAIN: if (drained) state_nx = rinse_cnt < rinse_target ? FILL : SPIN;
                   else if (timer == DRAIN_LAST) state_nx = FAULT;
            RINSE: if (!pause && timer == RINSE_LAST) state_nx = DRAIN;
            SPIN:  if (!pause && timer == SPIN_LAST) state_nx = DONE;
            DONE:  if (!start) state_nx = IDLE;
            FAULT: state_nx = FAULT;
`ifdef PRESOAK_EN
            SOAK:  if (!pause && timer == SOAK_LAST) state_nx = WASH;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            rinse_cnt    <= 3'd0;
            rinse_target <= 3'd0;
        end else begin
            state <= state_nx;
            timer <= state_nx != state ? '0 : (timed && pause) ? timer : timer + TIMER_W'(1);
            if (state == IDLE && state_nx == FILL) begin
                rinse_cnt    <= 3'd0;
                rinse_target <= mode == 2'd2 ? 3'(MAX_RINSE) : mode == 2'd1 ? 3'd2 : 3'd1;
            end
            if (state == DRAIN && state_nx == FILL) rinse_cnt <= rinse_cnt + 3'd1;
        end
    end

    always_comb begin
        door_lock      = state != IDLE && state != DONE;
        motor_on       = (state == WASH || state == RINSE || state == SPIN) && !pause;
        fill_valve_on  = state == FILL;
        drain_valve_on = state == DRAIN || state == SPIN;
        water_wash     = (state == FILL && rinse_cnt != 3'd0) || state == RINSE;
        done           = state == DONE;
        fault          = state == FAULT;
        state_out      = state;
    end
endmodule

// File: tb/tb_washing_machine_ctrl_multi.sv
// tb_washing_machine_ctrl_multi: directed checks of phase sequencing, pause, watchdog and door faults, and DONE handshake.
module tb_washing_machine_ctrl_multi;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, door_close = 1'b0, filled = 1'b0;
    logic detergent_added = 1'b0, drained = 1'b0, pause = 1'b0;
    logic [1:0] mode = 2'd0;
    logic door_lock, motor_on, fill_valve_on, drain_valve_on, water_wash, done, fault;
    logic [3:0] state_out;
    int vectors = 0, miscompares = 0, motor_cycles = 0, m0;

    // outputs packed as {lock, motor, fill, drain, wash, done, fault}
    localparam logic [6:0] O_IDLE = 7'b0000000, O_FILL = 7'b1010000, O_FILLR = 7'b1010100;
    localparam logic [6:0] O_WASH = 7'b1100000, O_DRAIN = 7'b1001000, O_RINSE = 7'b1100100;
    localparam logic [6:0] O_SPIN = 7'b1101000, O_DONE = 7'b0000010, O_FAULT = 7'b1000001;
    wire [6:0] outs = {door_lock, motor_on, fill_valve_on, drain_valve_on, water_wash, done, fault};

    washing_machine_ctrl_multi #(
        .TIMER_W(16), .WASH_TICKS(4), .RINSE_TICKS(3), .SPIN_TICKS(5),
        .FILL_TIMEOUT(8), .DRAIN_TIMEOUT(8), .MAX_RINSE(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .door_close(door_close), .filled(filled),
        .detergent_added(detergent_added), .drained(drained), .pause(pause), .mode(mode),
        .door_lock(door_lock), .motor_on(motor_on), .fill_valve_on(fill_valve_on),
        .drain_valve_on(drain_valve_on), .water_wash(water_wash), .done(done), .fault(fault),
        .state_out(state_out)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (motor_on === 1'b1) motor_cycles++;

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] st, input logic [6:0] o);
        chk({tag, " state"}, 32'(state_out), 32'(st));
        chk({tag, " outs"}, 32'(outs), 32'(o));
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(1);
        expect_st("reset", 4'd0, O_IDLE);
        reset = 1'b0; door_close = 1'b1; start = 1'b0; pause = 1'b0;
    endtask

    task automatic start_cycle(input logic [1:0] m, input bit hold);
        mode = m; start = 1'b1; door_close = 1'b1; tick(1);
        if (!hold) start = 1'b0;
        expect_st("fill1", 4'd1, O_FILL);
    endtask

    task automatic first_fill();
        tick(1); filled = 1'b1; detergent_added = 1'b1; tick(1);
        filled = 1'b0; detergent_added = 1'b0;
        expect_st("wash", 4'd2, O_WASH);
    endtask

    task automatic wash();
        tick(3); chk("wash hold", 32'(state_out), 32'd2);
        tick(1); expect_st("drain", 4'd3, O_DRAIN);
    endtask

    task automatic drain_to(input logic [3:0] st, input logic [6:0] o);
        tick(1); drained = 1'b1; tick(1); drained = 1'b0;
        expect_st("drain exit", st, o);
    endtask

    task automatic rinse();
        filled = 1'b1; tick(1); filled = 1'b0;
        expect_st("rinse", 4'd4, O_RINSE);
        tick(2); chk("rinse hold", 32'(state_out), 32'd4);
        tick(1); expect_st("rinse drain", 4'd3, O_DRAIN);
    endtask

    task automatic spin();
        tick(4); chk("spin hold", 32'(state_out), 32'd5);
        tick(1); expect_st("done", 4'd6, O_DONE);
    endtask

    initial begin
        tick(2);
        expect_st("reset", 4'd0, O_IDLE);
        reset = 1'b0; door_close = 1'b1;

        // quick mode: one rinse pass
        m0 = motor_cycles;
        start_cycle(2'd0, 1'b0); first_fill(); wash();
        drain_to(4'd1, O_FILLR); rinse();
        drain_to(4'd5, O_SPIN); spin();
        chk("motor mode0", 32'(motor_cycles - m0), 32'd12);
        tick(1); expect_st("idle", 4'd0, O_IDLE);

        // heavy mode: three rinse passes, fourth drain goes to spin
        start_cycle(2'd2, 1'b0); first_fill(); wash();
        for (int i = 0; i < 3; i++) begin
            drain_to(4'd1, O_FILLR); rinse();
        end
        drain_to(4'd5, O_SPIN); spin();
        tick(1); expect_st("idle2", 4'd0, O_IDLE);

        // pause for three cycles mid-wash
        m0 = motor_cycles;
        start_cycle(2'd0, 1'b0); first_fill(); tick(1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("pause motor", 32'(motor_on), 32'd0);
            chk("pause state", 32'(state_out), 32'd2);
            tick(1);
        end
        pause = 1'b0; #1;
        chk("unpause motor", 32'(motor_on), 32'd1);
        tick(2); chk("wash after pause", 32'(state_out), 32'd2);
        tick(1); expect_st("drain after pause", 4'd3, O_DRAIN);
        drain_to(4'd1, O_FILLR); rinse();
        drain_to(4'd5, O_SPIN); spin();
        chk("motor pause", 32'(motor_cycles - m0), 32'd12);
        tick(1);

        // fill watchdog
        start_cycle(2'd1, 1'b0); tick(7);
        expect_st("fill last", 4'd1, O_FILL);
        tick(1); expect_st("fill fault", 4'd7, O_FAULT);
        tick(5); expect_st("fault held", 4'd7, O_FAULT);
        do_reset();

        // filled on the watchdog's last cycle exits normally
        start_cycle(2'd1, 1'b0); tick(7);
        filled = 1'b1; detergent_added = 1'b1; tick(1);
        filled = 1'b0; detergent_added = 1'b0;
        expect_st("fill edge exit", 4'd2, O_WASH);
        do_reset();

        // door opened during spin
        start_cycle(2'd0, 1'b0); first_fill(); wash();
        drain_to(4'd1, O_FILLR); rinse(); drain_to(4'd5, O_SPIN);
        tick(2); door_close = 1'b0; tick(1);
        expect_st("door fault", 4'd7, O_FAULT);
        do_reset();

        // door opened on wash's last cycle: fault beats phase exit
        start_cycle(2'd0, 1'b0); first_fill(); tick(3);
        door_close = 1'b0; tick(1);
        chk("door prio", 32'(state_out), 32'd7);
        do_reset();

        // DONE holds while start stays high
        start_cycle(2'd0, 1'b1); first_fill(); wash();
        drain_to(4'd1, O_FILLR); rinse(); drain_to(4'd5, O_SPIN); spin();
        for (int i = 0; i < 10; i++) begin
            tick(1); chk("done hold", 32'(state_out), 32'd6);
        end
        start = 1'b0; tick(1); expect_st("done release", 4'd0, O_IDLE);
        start = 1'b1; tick(1); expect_st("restart", 4'd1, O_FILL);
        start = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
